// File: rtl/scoreboard_stall_unit.sv
// scoreboard_stall_unit: hazard and stall controller for the MIPS pipeline.
// It tracks outstanding integer and FP register writes using per-register
// latency countdowns. It detects RAW and WAW hazards, structural hazards on
// the shared MULT/DIV unit, and cache-miss stalls. It also sequences a
// SYSCALL drain-then-halt.
//
// Optional feature, macro SCOREBOARD_BYPASS_EN: a source register whose
// counter equals 1 is treated as ready, because it is forwarded at writeback.
// The WAW and structural checks do not change with the macro.
//
// COP1 (opcode 010001) is distinguished by func:
//   ADD_S=000000, SUB_S=000001, MUL_S=000010, DIV_S=000011,
//   MFC1=000100, MTC1=000101.
// FP operands use the same rs/rt/rd fields as integer instructions.
module scoreboard_stall_unit #(
  parameter int NUM_REGS   = 32,
  parameter int LOAD_LAT   = 1,
  parameter int MULDIV_LAT = 8,
  parameter int FP_LAT     = 3,
  parameter int MTC1_LAT   = 1
) (
  input  logic                clk,
  input  logic                rst_b,
  input  logic                inst_valid,
  input  logic [31:0]         inst_ID,
  input  logic                mem_access,
  input  logic                hit,
  output logic                issue,
  output logic                stall,
  output logic                pc_we,
  output logic                muldiv_busy,
  output logic [NUM_REGS-1:0] pending_int,
  output logic [NUM_REGS-1:0] pending_fp,
  output logic                halted
);

  localparam int RA_W    = $clog2(NUM_REGS);
  localparam int LAT_A   = (LOAD_LAT > MULDIV_LAT) ? LOAD_LAT : MULDIV_LAT;
  localparam int LAT_B   = (FP_LAT > MTC1_LAT) ? FP_LAT : MTC1_LAT;
  localparam int MAX_LAT = (LAT_A > LAT_B) ? LAT_A : LAT_B;
  localparam int CW      = ($clog2(MAX_LAT + 1) < 1) ? 1 : $clog2(MAX_LAT + 1);

  // Opcodes
  localparam logic [5:0] OP_RTYPE  = 6'b000000;
  localparam logic [5:0] OP_REGIMM = 6'b000001;
  localparam logic [5:0] OP_JAL    = 6'b000011;
  localparam logic [5:0] OP_BEQ    = 6'b000100;
  localparam logic [5:0] OP_BNE    = 6'b000101;
  localparam logic [5:0] OP_BLEZ   = 6'b000110;
  localparam logic [5:0] OP_BGTZ   = 6'b000111;
  localparam logic [5:0] OP_ADDI   = 6'b001000;
  localparam logic [5:0] OP_ADDIU  = 6'b001001;
  localparam logic [5:0] OP_SLTI   = 6'b001010;
  localparam logic [5:0] OP_ANDI   = 6'b001100;
  localparam logic [5:0] OP_ORI    = 6'b001101;
  localparam logic [5:0] OP_XORI   = 6'b001110;
  localparam logic [5:0] OP_LUI    = 6'b001111;
  localparam logic [5:0] OP_COP1   = 6'b010001;
  localparam logic [5:0] OP_LB     = 6'b100000;
  localparam logic [5:0] OP_LW     = 6'b100011;
  localparam logic [5:0] OP_SB     = 6'b101000;
  localparam logic [5:0] OP_SW     = 6'b101011;

  // R-type func codes
  localparam logic [5:0] F_SLL     = 6'b000000;
  localparam logic [5:0] F_SRL     = 6'b000010;
  localparam logic [5:0] F_SRA     = 6'b000011;
  localparam logic [5:0] F_SLLV    = 6'b000100;
  localparam logic [5:0] F_SRLV    = 6'b000110;
  localparam logic [5:0] F_JR      = 6'b001000;
  localparam logic [5:0] F_SYSCALL = 6'b001100;
  localparam logic [5:0] F_MULT    = 6'b011000;
  localparam logic [5:0] F_DIV     = 6'b011010;
  localparam logic [5:0] F_ADD     = 6'b100000;
  localparam logic [5:0] F_ADDU    = 6'b100001;
  localparam logic [5:0] F_SUB     = 6'b100010;
  localparam logic [5:0] F_SUBU    = 6'b100011;
  localparam logic [5:0] F_AND     = 6'b100100;
  localparam logic [5:0] F_OR      = 6'b100101;
  localparam logic [5:0] F_XOR     = 6'b100110;
  localparam logic [5:0] F_NOR     = 6'b100111;
  localparam logic [5:0] F_SLT     = 6'b101010;

  // COP1 func codes
  localparam logic [5:0] F_ADD_S   = 6'b000000;
  localparam logic [5:0] F_SUB_S   = 6'b000001;
  localparam logic [5:0] F_MUL_S   = 6'b000010;
  localparam logic [5:0] F_DIV_S   = 6'b000011;
  localparam logic [5:0] F_MFC1    = 6'b000100;
  localparam logic [5:0] F_MTC1    = 6'b000101;

  typedef enum logic [1:0] {S_RUN, S_DRAIN, S_HALTED} state_t;

  // Register usage of the ID instruction. Only tracked writes set wr_*.
  typedef struct packed {
    logic            rd_int_rs;
    logic            rd_int_rt;
    logic            rd_fp_rs;
    logic            rd_fp_rt;
    logic            wr_int;
    logic            wr_fp;
    logic [RA_W-1:0] dst;
    logic [CW-1:0]   lat;
    logic            muldiv;
    logic            syscall;
  } dec_t;

  logic [5:0]      opcode, func;
  logic [RA_W-1:0] rs, rt, rd;
  dec_t            dec;

  logic [CW-1:0] cnt_int [NUM_REGS];
  logic [CW-1:0] cnt_fp  [NUM_REGS];
  logic [CW-1:0] muldiv_cnt;

  state_t state_q, state_d;
  logic   mem_stall, raw, waw, structural, hazard;
  logic   unused_bits;

  assign opcode      = inst_ID[31:26];
  assign rs          = inst_ID[21 +: RA_W];
  assign rt          = inst_ID[16 +: RA_W];
  assign rd          = inst_ID[11 +: RA_W];
  assign func        = inst_ID[5:0];
  assign unused_bits = ^inst_ID[10:6];

`ifdef SCOREBOARD_BYPASS_EN
  // A value that completes this cycle is forwarded, so a count of 1 is ready.
  function automatic logic src_wait(input logic [CW-1:0] c);
    return c > CW'(1);
  endfunction
`else
  // A source is ready only when its write has fully retired.
  function automatic logic src_wait(input logic [CW-1:0] c);
    return c != '0;
  endfunction
`endif

  // Decode which registers the ID instruction reads and which tracked register it writes.
  always_comb begin
    // NOTE: every field gets a default first so that no decode path leaves a latch.
    dec     = '0;
    dec.dst = rd;
    case (opcode)
      OP_RTYPE: begin
        case (func)
          F_SLL, F_SRL, F_SRA: dec.rd_int_rt = 1'b1;
          F_ADD, F_SUB, F_AND, F_OR, F_XOR, F_NOR, F_SLT, F_ADDU, F_SUBU,
          F_SLLV, F_SRLV: begin
            dec.rd_int_rs = 1'b1;
            dec.rd_int_rt = 1'b1;
          end
          F_JR: dec.rd_int_rs = 1'b1;
          F_MULT, F_DIV: begin
            dec.rd_int_rs = 1'b1;
            dec.rd_int_rt = 1'b1;
            dec.wr_int    = 1'b1;
            dec.lat       = CW'(MULDIV_LAT);
            dec.muldiv    = 1'b1;
          end
          F_SYSCALL: dec.syscall = 1'b1;
          default: ;
        endcase
      end
      OP_REGIMM, OP_BLEZ, OP_BGTZ: dec.rd_int_rs = 1'b1;
      OP_BEQ, OP_BNE, OP_SW, OP_SB: begin
        dec.rd_int_rs = 1'b1;
        dec.rd_int_rt = 1'b1;
      end
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_ANDI, OP_ORI, OP_XORI, OP_LUI:
        dec.rd_int_rs = 1'b1;
      OP_LW, OP_LB: begin
        dec.rd_int_rs = 1'b1;
        dec.wr_int    = 1'b1;
        dec.dst       = rt;
        dec.lat       = CW'(LOAD_LAT);
      end
      OP_JAL: ;
      OP_COP1: begin
        case (func)
          F_ADD_S, F_SUB_S, F_MUL_S, F_DIV_S: begin
            dec.rd_fp_rs = 1'b1;
            dec.rd_fp_rt = 1'b1;
            dec.wr_fp    = 1'b1;
            dec.lat      = CW'(FP_LAT);
          end
          F_MFC1: dec.rd_fp_rs = 1'b1;
          F_MTC1: begin
            dec.rd_int_rt = 1'b1;
            dec.wr_fp     = 1'b1;
            dec.lat       = CW'(MTC1_LAT);
          end
          default: ;
        endcase
      end
      default: ;
    endcase
    // Integer r0 is hard-wired, so it is never marked pending.
    if (dec.dst == '0) dec.wr_int = 1'b0;
  end

  // Combine the hazard sources into the stall, issue and pc_we outputs.
  always_comb begin
    raw = (dec.rd_int_rs && (rs != '0) && src_wait(cnt_int[rs]))
        | (dec.rd_int_rt && (rt != '0) && src_wait(cnt_int[rt]))
        | (dec.rd_fp_rs  && src_wait(cnt_fp[rs]))
        | (dec.rd_fp_rt  && src_wait(cnt_fp[rt]));
    waw = (dec.wr_int && (cnt_int[dec.dst] != '0))
        | (dec.wr_fp  && (cnt_fp[dec.dst]  != '0));
    structural = dec.muldiv && muldiv_busy;
    hazard     = inst_valid && (raw || waw || structural);
    mem_stall  = mem_access && !hit;
    stall      = mem_stall || hazard || (state_q != S_RUN);
    issue      = inst_valid && !stall;
    pc_we      = !stall;
  end

  // Latency countdowns: these freeze on a cache miss, and an issuing destination reloads its counter.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      // NOTE: the counter arrays are flops, not RAM, and must reset so that
      // no stale in-flight write survives a reset.
      for (int i = 0; i < NUM_REGS; i++) begin
        cnt_int[i] <= '0;
        cnt_fp[i]  <= '0;
      end
      muldiv_cnt <= '0;
    end else if (!mem_stall) begin
      // NOTE: non-blocking assignments keep every counter reading last cycle's value.
      for (int i = 0; i < NUM_REGS; i++) begin
        if (issue && dec.wr_int && (dec.dst == RA_W'(i)))
          cnt_int[i] <= dec.lat;
        else if (cnt_int[i] != '0)
          cnt_int[i] <= cnt_int[i] - 1'b1;

        if (issue && dec.wr_fp && (dec.dst == RA_W'(i)))
          cnt_fp[i] <= dec.lat;
        else if (cnt_fp[i] != '0)
          cnt_fp[i] <= cnt_fp[i] - 1'b1;
      end
      if (issue && dec.muldiv)
        muldiv_cnt <= CW'(MULDIV_LAT);
      else if (muldiv_cnt != '0)
        muldiv_cnt <= muldiv_cnt - 1'b1;
    end
  end

  // Derive the pending bit vectors and the busy flag from the counters.
  always_comb begin
    pending_int = '0;
    pending_fp  = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      pending_int[i] = (cnt_int[i] != '0);
      pending_fp[i]  = (cnt_fp[i]  != '0);
    end
    muldiv_busy = (muldiv_cnt != '0);
  end

  // Halt sequencer state register.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) state_q <= S_RUN;
    else        state_q <= state_d;
  end

  // Halt sequencer next state: after an issued SYSCALL, drain all in-flight writes, then halt.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RUN:   if (issue && dec.syscall) state_d = S_DRAIN;
      S_DRAIN: if ((pending_int == '0) && (pending_fp == '0) && !muldiv_busy)
                 state_d = S_HALTED;
      S_HALTED: state_d = S_HALTED;
      default:  state_d = S_RUN;
    endcase
  end

  assign halted = (state_q == S_HALTED);

endmodule

// File: tb/tb_scoreboard_stall_unit.sv
// Directed testbench for scoreboard_stall_unit with the default parameters.
// Inputs change 1 ns after the rising edge. Outputs are sampled on the falling edge.
module tb_scoreboard_stall_unit;

  logic        clk = 1'b0;
  logic        rst_b;
  logic        inst_valid;
  logic [31:0] inst_ID;
  logic        mem_access;
  logic        hit;
  logic        issue, stall, pc_we, muldiv_busy, halted;
  logic [31:0] pending_int, pending_fp;

  int checks = 0;
  int errors = 0;

`ifdef SCOREBOARD_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  scoreboard_stall_unit dut (
    .clk         (clk),
    .rst_b       (rst_b),
    .inst_valid  (inst_valid),
    .inst_ID     (inst_ID),
    .mem_access  (mem_access),
    .hit         (hit),
    .issue       (issue),
    .stall       (stall),
    .pc_we       (pc_we),
    .muldiv_busy (muldiv_busy),
    .pending_int (pending_int),
    .pending_fp  (pending_fp),
    .halted      (halted)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [5:0] fn);
    return {6'b000000, rs, rt, rd, 5'b00000, fn};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt);
    return {op, rs, rt, 16'h0004};
  endfunction

  function automatic logic [31:0] enc_f(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [5:0] fn);
    return {6'b010001, rs, rt, rd, 5'b00000, fn};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic look();
    @(negedge clk);
  endtask

  initial begin
    rst_b      = 1'b0;
    inst_valid = 1'b0;
    inst_ID    = '0;
    mem_access = 1'b0;
    hit        = 1'b1;
    tick();
    tick();

    // Reset state
    look();
    check("rst_issue",  issue, 0);
    check("rst_stall",  stall, 0);
    check("rst_pc_we",  pc_we, 1);
    check("rst_busy",   muldiv_busy, 0);
    check("rst_pint",   pending_int, 0);
    check("rst_pfp",    pending_fp, 0);
    check("rst_halted", halted, 0);
    tick();
    rst_b = 1'b1;

    // LW r5 followed by ADD r6,r5,r1
    inst_valid = 1'b1;
    inst_ID    = enc_i(6'b100011, 5'd1, 5'd5);
    look();
    check("lw_issue", issue, 1);
    check("lw_stall", stall, 0);
    tick();
    inst_ID = enc_r(5'd5, 5'd1, 5'd6, 6'b100000);
    look();
    check("add_pint", pending_int, 32'h0000_0020);
    if (BYPASS) begin
      check("add_bypass_stall", stall, 0);
      check("add_bypass_issue", issue, 1);
      tick();
    end else begin
      check("add_raw_stall", stall, 1);
      check("add_raw_issue", issue, 0);
      check("add_raw_pc_we", pc_we, 0);
      tick();
      look();
      check("add_late_stall", stall, 0);
      check("add_late_issue", issue, 1);
      check("add_late_pint", pending_int, 0);
      tick();
    end
    inst_valid = 1'b0;

    // MULT r8, then DIV r9 stalls on the busy unit for 8 cycles
    inst_valid = 1'b1;
    inst_ID    = enc_r(5'd2, 5'd3, 5'd8, 6'b011000);
    look();
    check("mult_issue", issue, 1);
    tick();
    inst_ID = enc_r(5'd4, 5'd5, 5'd9, 6'b011010);
    for (int k = 0; k < 8; k++) begin
      look();
      check($sformatf("div_stall%0d", k), stall, 1);
      check($sformatf("div_busy%0d", k), muldiv_busy, 1);
      tick();
    end
    look();
    check("div_issue", issue, 1);
    check("div_busy_clear", muldiv_busy, 0);
    check("div_pint_at_issue", pending_int, 0);
    tick();
    inst_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      look();
      check($sformatf("div_r9_pending%0d", k), pending_int, 32'h0000_0200);
      tick();
    end
    look();
    check("div_r9_done", pending_int, 0);
    check("div_busy_done", muldiv_busy, 0);
    tick();

    // ADD_S f2,f1,f3, then MUL_S f4,f2,f2
    inst_valid = 1'b1;
    inst_ID    = enc_f(5'd1, 5'd3, 5'd2, 6'b000000);
    look();
    check("adds_issue", issue, 1);
    tick();
    inst_ID = enc_f(5'd2, 5'd2, 5'd4, 6'b000010);
    for (int k = 0; k < (BYPASS ? 2 : 3); k++) begin
      look();
      check($sformatf("muls_stall%0d", k), stall, 1);
      check($sformatf("muls_pfp%0d", k), pending_fp, 32'h0000_0004);
      tick();
    end
    look();
    check("muls_issue", issue, 1);
    check("muls_pfp_at_issue", pending_fp, BYPASS ? 32'h0000_0004 : 32'h0);
    tick();
    inst_valid = 1'b0;
    look();
    check("muls_f4_pending", pending_fp, 32'h0000_0010);
    tick();
    tick();
    tick();
    look();
    check("muls_f4_done", pending_fp, 0);
    tick();

    // Cache miss freezes r7 at count 2
    inst_valid = 1'b1;
    inst_ID    = enc_r(5'd1, 5'd2, 5'd7, 6'b011000);
    look();
    check("miss_mult_issue", issue, 1);
    tick();
    inst_valid = 1'b0;
    repeat (6) tick();
    mem_access = 1'b1;
    hit        = 1'b0;
    inst_valid = 1'b1;
    inst_ID    = enc_r(5'd1, 5'd2, 5'd10, 6'b100000);
    for (int k = 0; k < 4; k++) begin
      look();
      check($sformatf("miss_stall%0d", k), stall, 1);
      check($sformatf("miss_issue%0d", k), issue, 0);
      check($sformatf("miss_pint%0d", k), pending_int, 32'h0000_0080);
      tick();
    end
    hit = 1'b1;
    look();
    check("hit_stall", stall, 0);
    check("hit_issue", issue, 1);
    check("hit_pint", pending_int, 32'h0000_0080);
    tick();
    inst_valid = 1'b0;
    mem_access = 1'b0;
    look();
    check("hit_r7_one_left", pending_int, 32'h0000_0080);
    tick();
    look();
    check("hit_r7_done", pending_int, 0);
    check("hit_busy_done", muldiv_busy, 0);
    tick();

    // SYSCALL with DIV r12 having 5 cycles left
    inst_valid = 1'b1;
    inst_ID    = enc_r(5'd1, 5'd2, 5'd12, 6'b011010);
    look();
    check("sys_div_issue", issue, 1);
    tick();
    inst_valid = 1'b0;
    repeat (3) tick();
    inst_valid = 1'b1;
    inst_ID    = enc_r(5'd0, 5'd0, 5'd0, 6'b001100);
    look();
    check("sys_issue", issue, 1);
    check("sys_pint", pending_int, 32'h0000_1000);
    tick();
    inst_ID = enc_r(5'd1, 5'd2, 5'd10, 6'b100000);
    for (int k = 0; k < 5; k++) begin
      look();
      check($sformatf("drain_stall%0d", k), stall, 1);
      check($sformatf("drain_issue%0d", k), issue, 0);
      check($sformatf("drain_halted%0d", k), halted, 0);
      tick();
    end
    look();
    check("halt_set", halted, 1);
    check("halt_stall", stall, 1);
    check("halt_pc_we", pc_we, 0);
    check("halt_pint", pending_int, 0);
    tick();
    tick();
    look();
    check("halt_sticky", halted, 1);
    check("halt_no_issue", issue, 0);
    tick();

    // Reset in the middle of a MULT
    rst_b      = 1'b0;
    inst_valid = 1'b0;
    tick();
    rst_b      = 1'b1;
    inst_valid = 1'b1;
    inst_ID    = enc_r(5'd2, 5'd3, 5'd8, 6'b011000);
    look();
    check("rst2_mult_issue", issue, 1);
    tick();
    inst_valid = 1'b0;
    tick();
    tick();
    look();
    check("rst2_busy_before", muldiv_busy, 1);
    rst_b = 1'b0;
    #1;
    check("rst2_pint",   pending_int, 0);
    check("rst2_pfp",    pending_fp, 0);
    check("rst2_busy",   muldiv_busy, 0);
    check("rst2_stall",  stall, 0);
    check("rst2_pc_we",  pc_we, 1);
    check("rst2_halted", halted, 0);
    check("rst2_issue",  issue, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
